// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: priority/transparency select, then colour substitution and GRB unpack.
// Optional flash effect for one layer is compiled in when COMPOSITOR_FLASH_EN is defined.
module sprite_compositor #(
  parameter int          NUM_LAYERS      = 3,
  parameter logic [23:0] BG_COLOR        = 24'h002000,
  parameter logic [23:0] TRANSPARENT_KEY = 24'h000000,
  parameter int          FLASH_LAYER     = 0,
  parameter logic [23:0] FLASH_COLOR     = 24'hFFFFFF,
  parameter int          FLASH_PERIOD    = 4,
  parameter int          FLASH_PHASES    = 6
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              pix_valid,
  input  logic [9:0]                        DrawX,
  input  logic [9:0]                        DrawY,
  input  logic [NUM_LAYERS-1:0]             layer_hit,
  input  logic [24*NUM_LAYERS-1:0]          layer_data,
  input  logic                              frame_start,
  input  logic                              flash_req,
  output logic [7:0]                        VGA_R,
  output logic [7:0]                        VGA_G,
  output logic [7:0]                        VGA_B,
  output logic                              out_valid,
  output logic [9:0]                        out_x,
  output logic [9:0]                        out_y,
  output logic [$clog2(NUM_LAYERS+1)-1:0]   out_layer,
  output logic                              flash_active
);

  localparam int LW = $clog2(NUM_LAYERS + 1);
  localparam logic [LW-1:0] BG_IDX    = LW'(NUM_LAYERS);
  localparam logic [LW-1:0] FLASH_IDX = LW'(FLASH_LAYER);

  logic [NUM_LAYERS-1:0] opaque;
  logic [LW-1:0]         win_idx;
  logic [23:0]           win_data;

  logic [LW-1:0] s1_layer_reg;
  logic [23:0]   s1_data_reg;
  logic          s1_valid_reg;
  logic [9:0]    s1_x_reg;
  logic [9:0]    s1_y_reg;

  logic          flash_on;
  logic [23:0]   color_next;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
      assign opaque[gi] = layer_hit[gi] && (layer_data[24*gi +: 24] != TRANSPARENT_KEY);
    end
  endgenerate

  // Scan from lowest priority upward so the lowest opaque index is the last to overwrite.
  always_comb begin
    win_idx  = BG_IDX;
    win_data = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_idx  = LW'(i);
        win_data = layer_data[24*i +: 24];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_layer_reg <= '0;
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
    end else begin
      s1_layer_reg <= win_idx;
      s1_data_reg  <= win_data;
      s1_valid_reg <= pix_valid;
      s1_x_reg     <= DrawX;
      s1_y_reg     <= DrawY;
    end
  end

`ifdef COMPOSITOR_FLASH_EN
  localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int PW = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF} flash_state_t;

  flash_state_t  state_reg, state_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic [PW-1:0] phase_cnt_reg, phase_cnt_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      phase_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      phase_cnt_reg <= phase_cnt_next;
    end
  end

  // A request always restarts the sequence, even when it lands on a frame boundary.
  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    phase_cnt_next = phase_cnt_reg;
    if (flash_req) begin
      state_next     = ON;
      frame_cnt_next = FW'(FLASH_PERIOD - 1);
      phase_cnt_next = PW'(FLASH_PHASES - 1);
    end else if (frame_start && (state_reg != IDLE)) begin
      if (frame_cnt_reg != '0) begin
        frame_cnt_next = frame_cnt_reg - 1'b1;
      end else if (phase_cnt_reg != '0) begin
        state_next     = (state_reg == ON) ? OFF : ON;
        frame_cnt_next = FW'(FLASH_PERIOD - 1);
        phase_cnt_next = phase_cnt_reg - 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  assign flash_on     = (state_reg == ON);
  assign flash_active = (state_reg != IDLE);
`else
  logic unused_flash;
  assign unused_flash = flash_req ^ frame_start ^ (FLASH_PERIOD > 0) ^ (FLASH_PHASES > 0);
  assign flash_on     = 1'b0;
  assign flash_active = 1'b0;
`endif

  assign color_next = (flash_on && (s1_layer_reg == FLASH_IDX)) ? FLASH_COLOR : s1_data_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_layer <= '0;
    end else begin
      VGA_R     <= color_next[15:8];
      VGA_G     <= color_next[23:16];
      VGA_B     <= color_next[7:0];
      out_valid <= s1_valid_reg;
      out_x     <= s1_x_reg;
      out_y     <= s1_y_reg;
      out_layer <= s1_layer_reg;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised bench for sprite_compositor against a frame-counting reference model.
// Works with or without COMPOSITOR_FLASH_EN defined.
module tb_sprite_compositor;

  localparam logic [23:0] BG     = 24'h002000;
  localparam logic [23:0] KEY    = 24'h000000;
  localparam logic [23:0] FCOL   = 24'hFFFFFF;
  localparam logic [23:0] PLAYER = 24'h123456;
  localparam int          PERIOD = 4;
  localparam int          PHASES = 6;
`ifdef COMPOSITOR_FLASH_EN
  localparam bit FLASH_BUILD = 1'b1;
`else
  localparam bit FLASH_BUILD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [2:0]  layer_hit = '0;
  logic [71:0] layer_data = '0;
  logic        frame_start = 1'b0;
  logic        flash_req = 1'b0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;
  logic [9:0]  out_x, out_y;
  logic [1:0]  out_layer;
  logic        flash_active;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: stage-1 contents plus "frames elapsed since request".
  bit          m_s1_known = 1'b0;
  int          m_s1_layer = 0;
  logic [23:0] m_s1_color = '0;
  bit          m_s1_valid = 1'b0;
  logic [9:0]  m_s1_x = '0;
  logic [9:0]  m_s1_y = '0;
  bit          m_active = 1'b0;
  int          m_frames = 0;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .layer_hit(layer_hit), .layer_data(layer_data), .frame_start(frame_start),
    .flash_req(flash_req), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_layer(out_layer),
    .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_on();
    return m_active && (((m_frames / PERIOD) % 2) == 0);
  endfunction

  function automatic logic [71:0] rand_data();
    logic [71:0] d;
    for (int i = 0; i < 3; i++) begin
      case ($urandom_range(0, 5))
        0:       d[24*i +: 24] = KEY;
        1:       d[24*i +: 24] = PLAYER;
        default: d[24*i +: 24] = 24'($urandom);
      endcase
    end
    return d;
  endfunction

  // Entered and left at posedge+1; one pixel per call.
  task automatic step(input logic v, input logic [2:0] hit, input logic [71:0] data,
                      input logic fs, input logic fr);
    bit          e_known;
    int          e_layer;
    logic [23:0] e_color;
    bit          e_valid;
    logic [9:0]  e_x, e_y, x, y;
    int          w_layer;
    logic [23:0] w_color;
    bit          found;
    x = 10'($urandom_range(0, 1023));
    y = 10'($urandom_range(0, 1023));
    pix_valid = v; DrawX = x; DrawY = y; layer_hit = hit; layer_data = data;
    frame_start = fs; flash_req = fr;

    e_known = m_s1_known;
    e_layer = m_s1_layer;
    e_color = (model_on() && m_s1_layer == 0) ? FCOL : m_s1_color;
    e_valid = m_s1_valid;
    e_x = m_s1_x;
    e_y = m_s1_y;

    w_layer = 3; w_color = BG; found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && hit[i] && data[24*i +: 24] != KEY) begin
        found = 1'b1; w_layer = i; w_color = data[24*i +: 24];
      end
    end

    if (FLASH_BUILD) begin
      if (fr) begin
        m_active = 1'b1; m_frames = 0;
      end else if (fs && m_active) begin
        m_frames++;
        if (m_frames == PERIOD * PHASES) m_active = 1'b0;
      end
    end

    @(posedge Clk); #1;
    txn++;
    $display("txn %0d valid=%0d xy=%0d,%0d layer=%0d grb=%02h%02h%02h flash=%0d",
             txn, out_valid, out_x, out_y, out_layer, VGA_G, VGA_R, VGA_B, flash_active);
    if (e_known) begin
      check("vga_r", VGA_R, e_color[15:8]);
      check("vga_g", VGA_G, e_color[23:16]);
      check("vga_b", VGA_B, e_color[7:0]);
      check("out_layer", out_layer, e_layer);
      check("out_valid", out_valid, e_valid);
      check("out_x", out_x, e_x);
      check("out_y", out_y, e_y);
    end
    check("flash_active", flash_active, m_active);

    m_s1_known = 1'b1; m_s1_layer = w_layer; m_s1_color = w_color;
    m_s1_valid = v; m_s1_x = x; m_s1_y = y;
    frame_start = 1'b0; flash_req = 1'b0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_r"}, VGA_R, 8'h00);
    check({tag, "_g"}, VGA_G, 8'h00);
    check({tag, "_b"}, VGA_B, 8'h00);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_x"}, out_x, 10'd0);
    check({tag, "_y"}, out_y, 10'd0);
    check({tag, "_layer"}, out_layer, 2'd0);
    check({tag, "_flash"}, flash_active, 1'b0);
  endtask

  // Asynchronous reset raised between clock edges, released after one edge.
  task automatic mid_reset();
    #2 Reset = 1'b1;
    #1 reset_outputs_zero("mid_reset");
    m_active = 1'b0; m_frames = 0; m_s1_known = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [71:0] d;
    repeat (2) @(posedge Clk);
    #1;
    reset_outputs_zero("reset");
    Reset = 1'b0;

    // Background only.
    step(1'b1, 3'b000, rand_data(), 1'b0, 1'b0);
    step(1'b0, 3'b000, rand_data(), 1'b0, 1'b0);
    check("bg_r", VGA_R, 8'h20);
    check("bg_g", VGA_G, 8'h00);
    check("bg_b", VGA_B, 8'h00);
    check("bg_layer", out_layer, 2'd3);
    check("bg_valid", out_valid, 1'b1);

    // Layer 1 beats layer 2.
    d = {24'hAABBCC, 24'h112233, 24'h445566};
    step(1'b1, 3'b110, d, 1'b0, 1'b0);
    step(1'b1, 3'b000, rand_data(), 1'b0, 1'b0);
    check("prio_r", VGA_R, 8'h22);
    check("prio_g", VGA_G, 8'h11);
    check("prio_b", VGA_B, 8'h33);
    check("prio_layer", out_layer, 2'd1);

    // Transparent layer 0 falls through to layer 1.
    d = {24'h777777, 24'h0000FF, KEY};
    step(1'b1, 3'b011, d, 1'b0, 1'b0);
    step(1'b1, 3'b000, rand_data(), 1'b0, 1'b0);
    check("key_b", VGA_B, 8'hFF);
    check("key_layer", out_layer, 2'd1);

    // Full flash sequence on the player layer, frame_start every third cycle.
    d = rand_data(); d[23:0] = PLAYER;
    step(1'b1, 3'b001, d, 1'b0, 1'b1);
    check("flash_start", flash_active, FLASH_BUILD);
    for (int k = 0; k < 84; k++) begin
      d = rand_data(); d[23:0] = PLAYER;
      step(1'b1, 3'($urandom_range(0, 7)) | 3'b001, d, (k % 3) == 2, 1'b0);
    end
    check("flash_done", flash_active, 1'b0);

    // Restart landing on a frame boundary during an OFF phase.
    d = rand_data(); d[23:0] = PLAYER;
    step(1'b1, 3'b001, d, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b1, 3'b001, d, (k % 3) == 0, 1'b0);
    step(1'b1, 3'b001, d, 1'b1, 1'b1);
    step(1'b1, 3'b001, d, 1'b0, 1'b0);
    check("restart_g", VGA_G, FLASH_BUILD ? 8'hFF : 8'h12);
    for (int k = 0; k < 15; k++) step(1'b1, 3'b001, d, (k % 3) == 0, 1'b0);

    // Reset during an ON phase, then the player colour must be unmodified.
    step(1'b1, 3'b001, d, 1'b0, 1'b1);
    step(1'b1, 3'b001, d, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 3'b001, d, 1'b0, 1'b0);
    step(1'b1, 3'b001, d, 1'b0, 1'b0);
    check("post_reset_g", VGA_G, 8'h12);
    check("post_reset_r", VGA_R, 8'h34);
    check("post_reset_b", VGA_B, 8'h56);
    check("post_reset_flash", flash_active, 1'b0);

    // Free-running random traffic.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), rand_data(),
           $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined pixel compositor that merges NUM_LAYERS sprite layers plus a background colour into the VGA RGB stream. Sits between the sprite ROM/position logic (which supply per-layer hit flags and 24-bit GRB pixel data) and the VGA output pins. It adds a transparency key, a registered two-stage pipeline with coordinate pass-through, and a frame-timed flash effect for one designated layer, such as a player-hit blink.

## Interface
- NUM_LAYERS, 3: number of sprite layers; layer 0 has highest priority.
- BG_COLOR, 24'h002000: background pixel, GRB packed (G=[23:16], R=[15:8], B=[7:0]).
- TRANSPARENT_KEY, 24'h000000: layer pixel equal to this is treated as not drawn.
- FLASH_LAYER, 0: layer index affected by the flash effect.
- FLASH_COLOR, 24'hFFFFFF: GRB colour substituted during flash ON phases.
- FLASH_PERIOD, 4: frames per flash phase, ≥1.
- FLASH_PHASES, 6: phases per flash sequence (ON, OFF, ON, …), ≥1.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  DrawX/DrawY/layer inputs are valid this cycle.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- layer_hit  in  NUM_LAYERS  per-layer "pixel inside sprite" flags.
- layer_data  in  24*NUM_LAYERS  per-layer GRB pixel; layer i at [24*i+23:24*i].
- frame_start  in  1  one-cycle pulse at the start of each frame.
- flash_req  in  1  one-cycle pulse: start or restart the flash sequence.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.
- out_valid  out  1  pix_valid delayed 2 cycles.
- out_x, out_y  out  10 each  DrawX/DrawY delayed 2 cycles.
- out_layer  out  $clog2(NUM_LAYERS+1)  winning layer index; NUM_LAYERS = background.
- flash_active  out  1  flash sequence in progress (any phase).

## Operation
- Layer i is opaque when layer_hit[i]=1 and its data ≠ TRANSPARENT_KEY.
- Winner: the lowest-index opaque layer. If none is opaque, the background wins.
- Stage 1 (register): winner index, winner data, pix_valid, DrawX, DrawY.
- Stage 2 (register):
  - Colour substitution: if the winner is FLASH_LAYER and the flash FSM is in ON, use FLASH_COLOR. Otherwise use the winner data (BG_COLOR for background).
  - Unpacking: VGA_R=[15:8], VGA_G=[23:16], VGA_B=[7:0].
- When pix_valid=0, the pipeline still advances. Colour is computed normally and out_valid=0. There is no blanking forced inside the block.
- Flash FSM states:
  - IDLE, ON, OFF.
  - Counters: frame_cnt (FLASH_PERIOD-1 down to 0) and phase_cnt (phases remaining).
  - flash_req in any state → ON; frame_cnt=FLASH_PERIOD-1; phase_cnt=FLASH_PHASES-1.
  - frame_start in ON/OFF with frame_cnt>0 → frame_cnt decrements.
  - frame_start in ON/OFF with frame_cnt=0 and phase_cnt>0 → toggle ON↔OFF; frame_cnt reloads; phase_cnt decrements.
  - frame_start in ON/OFF with frame_cnt=0 and phase_cnt=0 → IDLE.
  - frame_start in IDLE is ignored.
  - flash_req and frame_start in the same cycle: flash_req wins (reload to ON).
  - flash_active=1 in ON or OFF (registered FSM state).

## Timing
- Latency: inputs at cycle N appear on VGA_*/out_* at cycle N+2. Throughput is one pixel per cycle with no stalls.
- The flash state used by stage 2 is the FSM state at the cycle stage 2 registers. A state change therefore affects pixels already in stage 1.
- Reset (asynchronous, any time, including mid-flash):
  - VGA_R/G/B=0, out_valid=0, out_x/out_y=0, out_layer=0.
  - FSM=IDLE, counters=0, flash_active=0.
  - First valid output after deassertion: 2 cycles after the first pix_valid.

## Configuration
- COMPOSITOR_FLASH_EN defined: flash FSM, counters, and the FLASH_COLOR substitution are compiled in as above.
- Not defined: no FSM logic. flash_req and frame_start are ignored, flash_active is tied to 0, and colour is always the winner data. Latency and all other behaviour are unchanged.

## Test plan
- Reset then pix_valid=1, no layer_hit → after 2 cycles R=8'h20, G=8'h00, B=8'h00, out_layer=3, out_valid=1.
- layer_hit=3'b110, layer1=24'h11_22_33, layer2=24'hAA_BB_CC → R=8'h22, G=8'h11, B=8'h33, out_layer=1.
- layer_hit=3'b011, layer0=TRANSPARENT_KEY, layer1=24'h0000FF → B=8'hFF, out_layer=1.
- COMPOSITOR_FLASH_EN defined, flash_req pulse, layer0 hit with 24'h123456:
  - Frames 0–3: white output.
  - Frames 4–7: 24'h123456 colour.
  - Pattern alternates; flash_active drops after the 24th frame_start.
  - flash_req coinciding with frame_start restarts at ON, frame_cnt=3.
- Reset asserted mid-pixel-stream during an ON phase → outputs 0 immediately, flash_active=0; after release, layer0 pixels show original colour.
